// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and write-back request type for the register-file write-back path.
package rf_wb_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests with async active-high reset.
module wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   push,
   input  logic                   pop,
   input  wb_req_t                din,
   output wb_req_t                dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   wb_req_t mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = count == (PW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rp];
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + {PW'(0), do_push} - {PW'(0), do_pop};
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file write port arbiter (ALU over buffered loads) with load scoreboard.
// Optional WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data showing next cycle's write.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        RST,
   input  logic                        alu_valid,
   input  logic [ADDR_W-1:0]           alu_rd,
   input  logic [DATA_W-1:0]           alu_data,
   input  logic                        ld_issue,
   input  logic [ADDR_W-1:0]           ld_issue_rd,
   input  logic                        ld_valid,
   output logic                        ld_ready,
   input  logic [ADDR_W-1:0]           ld_rd,
   input  logic [DATA_W-1:0]           ld_data,
   output logic                        WE3,
   output logic [ADDR_W-1:0]           A3,
   output logic [DATA_W-1:0]           WD3,
   output logic [31:0]                 pending,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef WB_FWD_EN
   ,
   output logic                        fwd_valid,
   output logic [ADDR_W-1:0]           fwd_rd,
   output logic [DATA_W-1:0]           fwd_data
`endif
);
   wb_req_t head, sel, wb_q;
   logic full, empty, alu_sel, fifo_sel, wr, push;
   logic [31:0] set_m, clr_m;
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .RST(RST),
      .push(push),
      .pop(fifo_sel),
      .din({ld_rd, ld_data}),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(fifo_count)
   );
   assign ld_ready = !RST && !full;
   // Returns to x0 are accepted but never buffered.
   assign push = ld_valid && ld_ready && ld_rd != REG_ZERO;
   assign alu_sel = alu_valid && alu_rd != REG_ZERO;
   assign fifo_sel = !alu_sel && !empty;
   assign wr = alu_sel || fifo_sel;
   assign sel = alu_sel ? wb_req_t'({alu_rd, alu_data}) : head;
   assign set_m = (ld_issue && ld_issue_rd != REG_ZERO) ? 32'd1 << ld_issue_rd : '0;
   assign clr_m = fifo_sel ? 32'd1 << head.rd : '0;
   assign A3 = wb_q.rd;
   assign WD3 = wb_q.data;
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         WE3 <= 1'b0;
         wb_q <= '0;
         pending <= '0;
      end else begin
         WE3 <= wr;
         if (wr) wb_q <= sel;
         pending <= (pending & ~clr_m) | set_m;
      end
   end
`ifdef WB_FWD_EN
   assign fwd_valid = !RST && wr;
   assign fwd_rd = sel.rd;
   assign fwd_data = sel.data;
`endif
endmodule
